seg_score_display: RTL



---
 rtl/seg_score_if.sv | 29 ++
 rtl/seg_score_display.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg_score_if.sv
// Request/result bundle between the game logic and seg_score_display.
// Optional blink input present only when SEG_BLINK_EN is defined.
interface seg_score_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
);
  // Handshake: load is taken on any clock edge where busy is low, and is ignored
  // otherwise. valid pulses for exactly one cycle when hex_out/overflow take a new result.
  logic [WIDTH-1:0]    value_in;
  logic                load;
  logic                busy;
  logic                valid;
  logic                overflow;
  logic [8*DIGITS-1:0] hex_out;
  logic [1:0]          state_dbg;
`ifdef SEG_BLINK_EN
  logic                blink;

  modport master (output value_in, load, blink,
                  input  busy, valid, overflow, hex_out, state_dbg);
  modport slave  (input  value_in, load, blink,
                  output busy, valid, overflow, hex_out, state_dbg);
`else
  modport master (output value_in, load,
                  input  busy, valid, overflow, hex_out, state_dbg);
  modport slave  (input  value_in, load,
                  output busy, valid, overflow, hex_out, state_dbg);
`endif
endinterface

// File: rtl/seg_score_display.sv
// Signed value to active-low seven-segment digits via sequential double-dabble.
// Optional blink blanking is enabled with the SEG_BLINK_EN macro.
module seg_score_display #(
  parameter int WIDTH     = 16,
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  seg_score_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int HEX_W = 8 * DIGITS;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  if (WIDTH < 2 || WIDTH > 32 || DIGITS < 1 || DIGITS > 8 || BLINK_DIV < 1) begin : g_param_check
    $error("seg_score_display: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_FORMAT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   iter;
  logic               last_iter;
  logic               sign;
  logic [WIDTH-1:0]   mag;
  logic [BCD_W-1:0]   bcd;
  logic               carry;
  logic [BCD_W-1:0]   bcd_adj, bcd_shift;
  logic [WIDTH-1:0]   mag_shift;
  logic               shift_out;
  logic [3:0]         nlen;
  logic [4:0]         need;
  logic               fmt_ovf;
  logic [HEX_W-1:0]   fmt_hex;
  logic [HEX_W-1:0]   result_q, result_d;
  logic               overflow_q, valid_q;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  assign last_iter = (iter == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.load) state_nxt = S_CONVERT;
      S_CONVERT: if (last_iter) state_nxt = S_FORMAT;
      S_FORMAT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.state_dbg = state;
  end

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, mag} left.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {shift_out, bcd_shift, mag_shift} = {bcd_adj, mag, 1'b0};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      iter  <= '0;
      sign  <= 1'b0;
      mag   <= '0;
      bcd   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.load) begin
          sign  <= bus.value_in[WIDTH-1];
          mag   <= bus.value_in[WIDTH-1] ? (~bus.value_in + 1'b1) : bus.value_in;
          bcd   <= '0;
          carry <= 1'b0;
          iter  <= '0;
        end
        S_CONVERT: begin
          bcd   <= bcd_shift;
          mag   <= mag_shift;
          carry <= carry | shift_out;
          iter  <= iter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking, sign placement and overflow dashes.
  always_comb begin
    nlen = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) nlen = 4'(i + 1);
    end
    need    = {1'b0, nlen} + {4'b0, sign};
    fmt_ovf = carry || (need > 5'(DIGITS));
    fmt_hex = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (fmt_ovf)                     fmt_hex[8*i +: 8] = SEG_DASH;
      else if (4'(i) < nlen)           fmt_hex[8*i +: 8] = glyph(bcd[4*i +: 4]);
      else if (4'(i) == nlen && sign)  fmt_hex[8*i +: 8] = SEG_DASH;
    end
  end

  assign result_d = (state == S_FORMAT) ? fmt_hex : result_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      result_q   <= '1;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= (state == S_FORMAT);
      if (state == S_FORMAT) overflow_q <= fmt_ovf;
    end
  end

  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0]    blink_cnt;
  logic             phase;
  logic [HEX_W-1:0] hex_q;

  // Blanking only masks the output register; result_q is never disturbed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
      hex_q     <= '1;
    end else begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      hex_q <= (bus.blink && phase) ? '1 : result_d;
    end
  end

  assign bus.hex_out = hex_q;
`else
  assign bus.hex_out = result_q;
`endif
endmodule
